// File: rtl/ddr2axis_pkg.sv
// ddr2axis_pkg: shared types and constants for the DDR-to-AXI-Stream frame reader.
// Holds the reader FSM state encoding, the fixed AXI field values and clogb2.
package ddr2axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AR_REQ = 2'd1,
    ST_R_DATA = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // Number of bits needed to hold bit_depth (clogb2(16) = 5).
  function automatic int clogb2(input int bit_depth);
    int d;
    int n;
    d = bit_depth;
    n = 0;
    while (d > 0) begin
      n = n + 1;
      d = d >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ddr2axis_rd.sv
// ddr2axis_rd: reads a frame from memory with single-outstanding AXI4 INCR bursts
// and forwards the read data as an AXI-Stream with TUSER on frame start and TLAST
// at every line end. Optional macro DDR2AXIS_CONTINUOUS_EN makes the reader
// restart the frame at the base address until stop is seen.
module ddr2axis_rd
  import ddr2axis_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h1000_0000,
  parameter int          C_M_AXI_BURST_LEN          = 16,
  parameter int          C_M_AXI_ID_WIDTH           = 1,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 128,
  parameter int          C_FRAME_BEATS              = 1024,
  parameter int          C_LINE_BEATS               = 64
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            start,
  input  logic                            stop,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TUSER,
  input  logic                            M_AXIS_TREADY
);

  localparam int AW         = C_M_AXI_ADDR_WIDTH;
  localparam int LP_BEAT_W  = (C_FRAME_BEATS > 1) ? $clog2(C_FRAME_BEATS) : 1;
  localparam int LP_BURST_W = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
  localparam int LP_LINE_W  = (C_LINE_BEATS > 1) ? $clog2(C_LINE_BEATS) : 1;
  localparam logic [AW-1:0] LP_BASE     = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [AW-1:0] LP_ADDR_INC = AW'(C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [AW-1:0]           r_araddr;
  logic [LP_BEAT_W-1:0]    r_beat_cnt;
  logic [LP_BURST_W-1:0]   r_burst_cnt;
  logic [LP_LINE_W-1:0]    r_line_cnt;
  logic                    r_err;
  logic                    w_hs;
  logic                    w_burst_end;
  logic                    w_frame_end;
  logic                    w_line_end;
  logic                    w_unused_rid;

  assign w_hs        = (r_state == ST_R_DATA) && M_AXI_RVALID && M_AXIS_TREADY;
  assign w_burst_end = (r_burst_cnt == LP_BURST_W'(C_M_AXI_BURST_LEN - 1));
  assign w_frame_end = (r_beat_cnt == LP_BEAT_W'(C_FRAME_BEATS - 1));
  assign w_line_end  = (r_line_cnt == LP_LINE_W'(C_LINE_BEATS - 1));
  assign w_unused_rid = ^M_AXI_RID;

`ifdef DDR2AXIS_CONTINUOUS_EN
  logic r_stop_seen;
  logic w_stop;

  assign w_stop = r_stop_seen | stop;

  // Remember a stop request made while a frame is in flight.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_stop_seen <= 1'b0;
    end else if (r_state == ST_IDLE || r_state == ST_DONE) begin
      r_stop_seen <= 1'b0;
    end else if (stop) begin
      r_stop_seen <= 1'b1;
    end
  end
`else
  logic w_unused_stop;
  assign w_unused_stop = stop;
`endif

  // State register.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; burst and frame boundaries follow the internal beat count, RLAST is only checked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_AR_REQ;
      ST_AR_REQ: if (M_AXI_ARREADY) w_state_nxt = ST_R_DATA;
      ST_R_DATA: begin
        if (w_hs && w_frame_end) begin
          w_state_nxt = ST_DONE;
        end else if (w_hs && w_burst_end) begin
          w_state_nxt = ST_AR_REQ;
        end
      end
      ST_DONE: begin
`ifdef DDR2AXIS_CONTINUOUS_EN
        w_state_nxt = w_stop ? ST_IDLE : ST_AR_REQ;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State-dependent outputs: AR request, stream pass-through gating, status.
  always_comb begin
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TUSER  = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    done          = 1'b0;
    busy          = (r_state != ST_IDLE);
    case (r_state)
      ST_AR_REQ: M_AXI_ARVALID = 1'b1;
      ST_R_DATA: begin
        M_AXIS_TVALID = M_AXI_RVALID;
        M_AXI_RREADY  = M_AXIS_TREADY;
        M_AXIS_TUSER  = (r_beat_cnt == '0);
        M_AXIS_TLAST  = w_line_end;
      end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  // Burst address and sticky error flag.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_araddr <= LP_BASE;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_araddr <= LP_BASE;
        r_err    <= 1'b0;
      end else if (r_state == ST_DONE) begin
        r_araddr <= LP_BASE;
      end else if (r_state == ST_AR_REQ && M_AXI_ARREADY) begin
        r_araddr <= r_araddr + LP_ADDR_INC;
      end
      if (w_hs && ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != w_burst_end))) begin
        r_err <= 1'b1;
      end
    end
  end

  // Frame, burst and line beat counters; they wrap to zero at their boundaries.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_line_cnt  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_line_cnt  <= '0;
    end else if (w_hs) begin
      r_beat_cnt  <= w_frame_end ? '0 : r_beat_cnt + 1'b1;
      r_burst_cnt <= w_burst_end ? '0 : r_burst_cnt + 1'b1;
      r_line_cnt  <= w_line_end  ? '0 : r_line_cnt + 1'b1;
    end
  end

  assign err           = r_err;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'(clogb2(C_M_AXI_DATA_WIDTH / 8) - 1);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_DEFAULT;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXIS_TDATA  = M_AXI_RDATA;
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_ddr2axis_rd.sv
// tb_ddr2axis_rd: bench for ddr2axis_rd with a small frame (64 beats, 32-beat lines,
// 16-beat bursts). A memory slave returns word n at beat n; a reference model tracks
// the expected frame beat index, burst addresses and error outcome per scenario.
module tb_ddr2axis_rd;

  localparam int FB = 64;
  localparam int LB = 32;
  localparam int BL = 16;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start, stop, busy, done, err;
  logic [0:0]    arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic [3:0]    arqos;
  logic          arvalid, arready;
  logic [0:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tvalid, tlast, tuser, tready;

  ddr2axis_rd #(
    .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
    .C_M_AXI_BURST_LEN(BL),
    .C_M_AXI_ID_WIDTH(1),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_FRAME_BEATS(FB),
    .C_LINE_BEATS(LB)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .start(start), .stop(stop), .busy(busy), .done(done), .err(err),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TLAST(tlast), .M_AXIS_TUSER(tuser), .M_AXIS_TREADY(tready)
  );

  typedef struct {
    int mode;       // 0: TREADY always, 1: TREADY 1 in 3, 2: random handshakes
    int rb;         // burst index carrying RRESP=SLVERR at beat resp_beat (-1 none)
    int lb;         // burst index with an early RLAST on beat 14 (-1 none)
    bit mid_start;  // pulse start again while the frame is running
    bit exp_err;
    int exp_beats;
    int exp_ars;
    int exp_done;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // slave / model state
  int cyc = 0;
  int tr_mode = 0, resp_burst = -1, resp_beat = 5, rlast_burst = -1;
  bit sl_active = 0;
  int sl_word = 0, sl_beat = 0, sl_burst = 0;
  int ar_total = 0, beat_total = 0, done_cnt = 0;
  int pass_mism = 0, outst_mism = 0;
  bit start_req = 0, stop_req = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    ar_total = 0; beat_total = 0; done_cnt = 0;
    pass_mism = 0; outst_mism = 0; sl_active = 0; sl_beat = 0;
  endtask

  // One clock: drive at the falling edge, sample 2ns later (well before the rising edge).
  task automatic cycle();
    int bi;
    @(negedge clk);
    cyc++;
    start = start_req; start_req = 0;
    stop  = stop_req;  stop_req  = 0;
    arready = ($urandom_range(0, 2) != 0);
    case (tr_mode)
      0:       tready = 1'b1;
      1:       tready = (cyc % 3 == 0);
      default: tready = ($urandom_range(0, 1) == 1);
    endcase
    if (sl_active) begin
      rvalid = (tr_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdata  = DW'(sl_word + sl_beat);
      rlast  = (sl_beat == BL - 1) || (rlast_burst == sl_burst && sl_beat == 14);
      rresp  = (resp_burst == sl_burst && sl_beat == resp_beat) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
    end
    #2;
    if (sl_active) begin
      if (rready !== tready || tvalid !== rvalid || tdata !== rdata) pass_mism++;
      if (arvalid) outst_mism++;
    end else if (rready !== 1'b0 || tvalid !== 1'b0) begin
      pass_mism++;
    end
    if (tstrb !== '1) pass_mism++;
    if (done) done_cnt++;
    if (arvalid && arready) begin
      chk("ar_addr", araddr, BASE + 32'((ar_total % (FB / BL)) * BL * (DW / 8)));
      chk("ar_fields", {arlen, arsize, arburst, arcache, arid, arlock, arprot, arqos},
          {8'd15, 3'd4, 2'b01, 4'b0011, 1'b0, 1'b0, 3'b000, 4'b0000});
      sl_active = 1;
      sl_word   = int'((araddr - BASE) >> 4);
      sl_beat   = 0;
      sl_burst  = ar_total % (FB / BL);
      ar_total++;
    end else if (sl_active && rvalid && rready) begin
      bi = beat_total % FB;
      chk("tdata", tdata, DW'(bi));
      chk("tuser", tuser, (bi == 0));
      chk("tlast", tlast, (bi % LB == LB - 1));
      beat_total++;
      sl_beat++;
      if (sl_beat == BL) sl_active = 0;
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    bit timeout;
    bit mid_done;
    logic err_done;
    clear_model();
    tr_mode = v.mode; resp_burst = v.rb; rlast_burst = v.lb;
    resp_beat = 5;
    mid_done = 0; err_done = 1'bx; timeout = 1;
    start_req = 1;
    cycle();
    stop_req = 1;
    cycle();
    chk({tag, "_busy_run"}, busy, 1'b1);
    chk({tag, "_err_clr"}, err, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if (v.mid_start && !mid_done && beat_total >= 4) begin
        start_req = 1;
        mid_done = 1;
      end
      cycle();
      if (done) begin
        err_done = err;
        timeout = 0;
        break;
      end
    end
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_err_at_done"}, err_done, v.exp_err);
    repeat (6) cycle();
    chk({tag, "_beats"}, beat_total, v.exp_beats);
    chk({tag, "_ars"}, ar_total, v.exp_ars);
    chk({tag, "_dones"}, done_cnt, v.exp_done);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_err_sticky"}, err, v.exp_err);
    chk({tag, "_passthru"}, pass_mism, 0);
    chk({tag, "_one_outstanding"}, outst_mism, 0);
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_arvalid"}, arvalid, 1'b0);
    chk({tag, "_araddr"}, araddr, BASE);
    chk({tag, "_rready"}, rready, 1'b0);
    chk({tag, "_tvalid"}, tvalid, 1'b0);
    chk({tag, "_tlast"}, tlast, 1'b0);
    chk({tag, "_tuser"}, tuser, 1'b0);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    bit tmo;
    bit stopped;
    tbl[0] = '{0, -1, -1, 0, 0, 64, 4, 1};  // full-rate stream
    tbl[1] = '{1, -1, -1, 0, 0, 64, 4, 1};  // TREADY one cycle in three
    tbl[2] = '{0,  1, -1, 0, 1, 64, 4, 1};  // SLVERR on burst 2 beat 5
    tbl[3] = '{2, -1, -1, 0, 0, 64, 4, 1};  // random handshakes, err cleared by start
    tbl[4] = '{0, -1,  1, 0, 1, 64, 4, 1};  // early RLAST on beat 14
    tbl[5] = '{2, -1, -1, 1, 0, 64, 4, 1};  // stray start mid-frame

    start = 0; stop = 0; arready = 0; rid = '0; rdata = '0; rresp = 2'b00;
    rlast = 0; rvalid = 0; tready = 0;

    #1 rst = 1'b1;
    #1 reset_outputs_chk("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_frame(tbl[k], $sformatf("vec%0d", k));

    // Randomized frames; expected error follows from whether a fault was injected.
    for (int r = 0; r < 3; r++) begin
      v.mode = 2;
      v.rb = $urandom_range(0, 5);
      v.lb = $urandom_range(0, 7);
      v.mid_start = ($urandom_range(0, 1) == 1);
      v.exp_err = (v.rb < FB / BL) || (v.lb < FB / BL);
      v.exp_beats = FB; v.exp_ars = FB / BL; v.exp_done = 1;
      if (v.rb >= FB / BL) v.rb = -1;
      if (v.lb >= FB / BL) v.lb = -1;
      run_frame(v, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of the second burst, then a clean frame from base.
    clear_model();
    tr_mode = 0; resp_burst = -1; rlast_burst = -1;
    start_req = 1;
    tmo = 1;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (beat_total >= 20) begin tmo = 0; break; end
    end
    chk("midrst_reach", tmo, 1'b0);
    @(negedge clk);
    rvalid = 1'b1; tready = 1'b1; arready = 1'b1;
    rst = 1'b1;
    #1 reset_outputs_chk("midrst");
    sl_active = 0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(tbl[0], "after_rst");

`ifdef DDR2AXIS_CONTINUOUS_EN
    // Continuous mode: frame restarts at base; stop in frame 2 ends after frame 2.
    clear_model();
    tr_mode = 0; resp_burst = -1; rlast_burst = -1;
    start_req = 1;
    stopped = 0; tmo = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!stopped && beat_total >= FB + 8) begin stop_req = 1; stopped = 1; end
      cycle();
      if (done_cnt == 2) begin tmo = 0; break; end
    end
    chk("cont_timeout", tmo, 1'b0);
    repeat (10) cycle();
    chk("cont_ars", ar_total, 2 * FB / BL);
    chk("cont_beats", beat_total, 2 * FB);
    chk("cont_dones", done_cnt, 2);
    chk("cont_idle", busy, 1'b0);
`else
    // Without continuous mode the reader stays idle after its frame.
    clear_model();
    stopped = 0;
    repeat (20) cycle();
    chk("idle_no_ar", ar_total, 0);
    chk("idle_no_done", done_cnt, 0);
    chk("idle_busy", busy, stopped);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr2axis_rd.md
DDR2AXIS_RD -- requirements
Module: ddr2axis_rd

Interface
REQ-001 C_M_TARGET_SLAVE_BASE_ADDR, 32'h10000000, byte address of frame start.
REQ-002 C_M_AXI_BURST_LEN, 16, beats per AR burst; values 1,2,4,...,256.
REQ-003 C_M_AXI_ID_WIDTH, 1; C_M_AXI_ADDR_WIDTH, 32; C_M_AXI_DATA_WIDTH, 128.
REQ-004 C_FRAME_BEATS, 1024, beats per frame; must be a multiple of C_M_AXI_BURST_LEN.
REQ-005 C_LINE_BEATS, 64, beats per line; must divide C_FRAME_BEATS.
REQ-006 M_AXI_ACLK  in  1  sole clock; all logic is rising-edge.
REQ-007 M_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins a frame read; stop  in  1  ends continuous mode at the next frame boundary.
REQ-009 busy  out  1  frame in progress; done  out  1  one-cycle pulse after the last beat of a frame; err  out  1  sticky error flag.
REQ-010 M_AXI_ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]/ARLOCK/ARCACHE[4]/ARPROT[3]/ARQOS[4]/ARVALID  out; M_AXI_ARREADY  in.
REQ-011 M_AXI_RID/RDATA/RRESP[2]/RLAST/RVALID  in; M_AXI_RREADY  out.
REQ-012 M_AXIS_TDATA  out  DATA_WIDTH; M_AXIS_TSTRB  out  DATA_WIDTH/8; M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER  out  1; M_AXIS_TREADY  in  1.

Function
REQ-013 FSM states: IDLE, AR_REQ, R_DATA, DONE; IDLE->AR_REQ on start; AR_REQ->R_DATA on ARVALID&ARREADY; R_DATA->AR_REQ on RLAST handshake with beats remaining; R_DATA->DONE on final handshake; DONE->IDLE after one cycle.
REQ-014 Exactly one burst outstanding; ARVALID is held until ARREADY, with ARADDR stable.
REQ-015 ARADDR starts at base; each accepted burst advances it by BURST_LEN*DATA_WIDTH/8 bytes, modulo 2^ADDR_WIDTH.
REQ-016 Constant AR fields: ARLEN=BURST_LEN-1, ARSIZE=clogb2(DATA_WIDTH/8)-1, ARBURST=2'b01, ARID=0, ARLOCK=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0.
REQ-017 In R_DATA the stream is a zero-latency pass-through: TVALID=RVALID, TDATA=RDATA, RREADY=TREADY; outside R_DATA, TVALID=0 and RREADY=0.
REQ-018 TSTRB is all ones.
REQ-019 TUSER=1 only on frame beat 0.
REQ-020 TLAST=1 on every beat whose index mod C_LINE_BEATS equals C_LINE_BEATS-1.
REQ-021 Beat counter and line counter advance only on the RVALID&RREADY handshake.
REQ-022 err sets on any handshake with RRESP!=2'b00, or when RLAST disagrees with the internal burst-beat count; the frame still completes; err clears on an accepted start.
REQ-023 start is ignored unless the state is IDLE; busy=1 in every state except IDLE.
REQ-024 done pulses for one cycle while the state is DONE.

Reset
REQ-025 Asserting M_AXI_ARESET immediately forces state=IDLE, counters=0, ARADDR=base, ARVALID=0, RREADY=0, TVALID=0, TLAST=0, TUSER=0, busy=0, done=0, err=0.
REQ-026 Reset mid-burst abandons the transaction; the next start begins again at base.

Configuration
REQ-027 Macro DDR2AXIS_CONTINUOUS_EN defined: DONE->AR_REQ at base with a done pulse every frame, unless stop was seen during the frame, in which case DONE->IDLE.
REQ-028 Macro DDR2AXIS_CONTINUOUS_EN undefined: DONE->IDLE always, and stop is ignored.

Structure
REQ-029 Package ddr2axis_pkg holds: FSM state enum, AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00, CACHE_DEFAULT=4'b0011), and the clogb2 function.
REQ-030 No sub-module is required; the block is a single module.

Verification (bench: FRAME_BEATS=64, LINE_BEATS=32, BURST_LEN=16, memory word n = n)
REQ-031 start, TREADY=1 -> 4 ARs at 0x10000000/0x10000100/0x10000200/0x10000300, each ARLEN=15; TDATA 0..63; TUSER on beat 0 only; TLAST on beats 31 and 63; exactly one done.
REQ-032 TREADY high 1 cycle in every 3 -> TDATA 0..63 with no loss or duplication; RREADY equals TREADY throughout R_DATA.
REQ-033 RRESP=2'b10 on burst 2, beat 5 -> err=1 through DONE, 64 beats still delivered; next start clears err.
REQ-034 Slave asserts RLAST on beat 14 of a burst -> err=1.
REQ-035 start pulsed during burst 1 -> ignored; exactly 4 ARs total.
REQ-036 Reset during burst 2 -> all outputs at their reset values in the same cycle; next start issues its AR at 0x10000000.
REQ-037 DDR2AXIS_CONTINUOUS_EN defined -> after beat 63, next AR is at 0x10000000 without start; stop during frame 2 -> IDLE after frame 2, with 2 done pulses total.
